// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings for the pipelined multiplier's accumulate mode.
package mul_pkg;
  localparam int ACC_OPW = 2;
  typedef enum logic [ACC_OPW-1:0] {
    ACC_NONE = 2'b00,
    ACC_ADD  = 2'b01,
    ACC_SUB  = 2'b10
  } acc_op_e;
endpackage

// File: rtl/mul_pipe_reg.sv
// mul_pipe_reg: one valid+data pipeline stage; data loads only with a live op so the last value persists.
module mul_pipe_reg #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stall,
  input  logic          cancel,
  input  logic          in_valid,
  input  logic [DW-1:0] d,
  output logic          valid,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk)
    if (!resetn) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (cancel) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= in_valid;
      if (in_valid) q <= d;
    end
endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined WIDTH x WIDTH multiplier with stall/cancel; MUL_ACC_EN adds MADD/MSUB accumulate.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_ACC_EN
  input  logic [ACC_OPW-1:0] acc_op,
  input  logic [2*WIDTH-1:0] acc_in,
`endif
  input  logic               stall,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] res,
  output logic               out_valid,
  output logic               busy
);
  localparam int PW = 2*WIDTH;
`ifdef MUL_ACC_EN
  localparam int AW = ACC_OPW + PW;
`else
  localparam int AW = 0;
`endif
  localparam int OW = 2*WIDTH + 2 + AW;
  localparam int MW = PW + AW;

  logic [DEPTH:0] v;
  logic [OW-1:0]  opnd;

  assign v[0]      = in_valid;
  assign out_valid = v[DEPTH];

`ifdef MUL_ACC_EN
  assign opnd = {acc_op, acc_in, is_signed & a[WIDTH-1], a, is_signed & b[WIDTH-1], b};
`else
  assign opnd = {is_signed & a[WIDTH-1], a, is_signed & b[WIDTH-1], b};
`endif

  // Only the low PW product bits are kept, so a PW-wide signed multiply of the extended operands suffices.
  function automatic logic [MW-1:0] multiply(input logic [OW-1:0] o);
    logic [PW-1:0] p;
    p = PW'($signed(o[2*WIDTH+1:WIDTH+1]) * $signed(o[WIDTH:0]));
`ifdef MUL_ACC_EN
    return {o[OW-1:2*WIDTH+2], p};
`else
    return p;
`endif
  endfunction

  function automatic logic [PW-1:0] apply_acc(input logic [MW-1:0] m);
`ifdef MUL_ACC_EN
    logic [ACC_OPW-1:0] op;
    logic [PW-1:0]      acc;
    {op, acc} = m[MW-1:PW];
    return op == ACC_ADD ? acc + m[PW-1:0] : op == ACC_SUB ? acc - m[PW-1:0] : m[PW-1:0];
`else
    return m;
`endif
  endfunction

  if (DEPTH == 1) begin : g_flat
    mul_pipe_reg #(.DW(PW)) u_out (
      .clk, .resetn, .stall, .cancel,
      .in_valid(v[0]), .d(apply_acc(multiply(opnd))), .valid(v[1]), .q(res)
    );
    assign busy = 1'b0;
  end else begin : g_deep
    logic [OW-1:0] opnd_q;
    logic [MW-1:0] mid [DEPTH-1];
    mul_pipe_reg #(.DW(OW)) u_opnd (
      .clk, .resetn, .stall, .cancel,
      .in_valid(v[0]), .d(opnd), .valid(v[1]), .q(opnd_q)
    );
    assign mid[0] = multiply(opnd_q);
    // Middle stages only carry the product, leaving room for retiming the multiplier across them.
    for (genvar i = 1; i < DEPTH-1; i++) begin : g_mid
      mul_pipe_reg #(.DW(MW)) u_mid (
        .clk, .resetn, .stall, .cancel,
        .in_valid(v[i]), .d(mid[i-1]), .valid(v[i+1]), .q(mid[i])
      );
    end
    mul_pipe_reg #(.DW(PW)) u_out (
      .clk, .resetn, .stall, .cancel,
      .in_valid(v[DEPTH-1]), .d(apply_acc(mid[DEPTH-2])), .valid(v[DEPTH]), .q(res)
    );
    assign busy = |v[DEPTH-1:1];
  end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed vector table plus stall/cancel/reset sequences for mul_pipe (WIDTH=32, DEPTH=3).
module tb_mul_pipe;
  localparam int W = 32;
  localparam int D = 3;

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic [63:0]   acc;
    logic [63:0]   exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    acc_op = '0;
  logic [63:0]   acc_in = '0;
  logic          stall = 1'b0;
  logic          cancel = 1'b0;
  logic [63:0]   res;
  logic          out_valid;
  logic          busy;
  int            checks = 0;
  int            errors = 0;
  vec_t          vecs[$];

  mul_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .is_signed(is_signed),
    .a(a),
    .b(b),
`ifdef MUL_ACC_EN
    .acc_op(acc_op),
    .acc_in(acc_in),
`endif
    .stall(stall),
    .cancel(cancel),
    .res(res),
    .out_valid(out_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t t);
    in_valid  = 1'b1;
    is_signed = t.sgn;
    a         = t.a;
    b         = t.b;
    acc_op    = t.op;
    acc_in    = t.acc;
  endtask

  function automatic vec_t mk(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic [63:0] e);
    return '{sgn: s, a: x, b: y, op: 2'b00, acc: 64'h0, exp: e};
  endfunction

  initial begin
    vecs.push_back(mk(1'b1, 32'hFFFFFFFF, 32'h2,        64'hFFFFFFFF_FFFFFFFE));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001));
    vecs.push_back(mk(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000));
    vecs.push_back(mk(1'b1, 32'h80000000, 32'h1,        64'hFFFFFFFF_80000000));
    vecs.push_back(mk(1'b0, 32'h80000000, 32'h1,        64'h00000000_80000000));
    vecs.push_back(mk(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001));
    vecs.push_back(mk(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001));
    vecs.push_back(mk(1'b0, 32'h0,        32'h12345678, 64'h0));
    vecs.push_back(mk(1'b1, 32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF_FFFFFFFA));
    vecs.push_back(mk(1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000));
`ifdef MUL_ACC_EN
    vecs.push_back('{sgn: 1'b1, a: 32'd3, b: 32'd5, op: 2'b10, acc: 64'h10, exp: 64'h1});
    vecs.push_back('{sgn: 1'b1, a: 32'd1, b: 32'd1, op: 2'b01, acc: 64'hFFFFFFFF_FFFFFFFF, exp: 64'h0});
    vecs.push_back('{sgn: 1'b0, a: 32'd3, b: 32'd5, op: 2'b11, acc: 64'h123, exp: 64'd15});
    vecs.push_back('{sgn: 1'b1, a: 32'hFFFFFFFF, b: 32'd4, op: 2'b01, acc: 64'd10, exp: 64'd6});
`endif

    step();
    step();
    chk("reset out_valid", 64'(out_valid), 64'h0);
    chk("reset res", res, 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    resetn = 1'b1;
    step();

    foreach (vecs[i]) begin
      set_in(vecs[i]);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d busy", i), 64'(busy), 64'h1);
      chk($sformatf("v%0d early0", i), 64'(out_valid), 64'h0);
      step();
      chk($sformatf("v%0d early1", i), 64'(out_valid), 64'h0);
      step();
      chk($sformatf("v%0d valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d res", i), res, vecs[i].exp);
      step();
      chk($sformatf("v%0d pulse", i), 64'(out_valid), 64'h0);
      chk($sformatf("v%0d hold", i), res, vecs[i].exp);
      chk($sformatf("v%0d idle", i), 64'(busy), 64'h0);
    end

    for (int k = 0; k <= vecs.size() + D - 1; k++) begin
      if (k < vecs.size()) set_in(vecs[k]);
      else in_valid = 1'b0;
      step();
      if (k - (D - 1) >= 0 && k - (D - 1) < vecs.size()) begin
        chk($sformatf("stream%0d valid", k), 64'(out_valid), 64'h1);
        chk($sformatf("stream%0d res", k), res, vecs[k-(D-1)].exp);
      end else begin
        chk($sformatf("stream%0d idle", k), 64'(out_valid), 64'h0);
      end
    end
    in_valid = 1'b0;
    step();

    set_in(mk(1'b0, 32'd3, 32'd4, 64'd12));
    step();
    stall = 1'b1;
    set_in(mk(1'b0, 32'd9, 32'd9, 64'd81));
    step();
    chk("stall busy", 64'(busy), 64'h1);
    chk("stall out0", 64'(out_valid), 64'h0);
    step();
    chk("stall out1", 64'(out_valid), 64'h0);
    stall = 1'b0;
    in_valid = 1'b0;
    step();
    chk("stall out2", 64'(out_valid), 64'h0);
    step();
    chk("stall late valid", 64'(out_valid), 64'h1);
    chk("stall late res", res, 64'd12);
    stall = 1'b1;
    set_in(mk(1'b0, 32'd2, 32'd2, 64'd4));
    step();
    chk("out stall valid0", 64'(out_valid), 64'h1);
    chk("out stall res0", res, 64'd12);
    step();
    chk("out stall valid1", 64'(out_valid), 64'h1);
    stall = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall drop%0d", k), 64'(out_valid), 64'h0);
    end
    chk("stall drop res", res, 64'd12);

    set_in(mk(1'b0, 32'd5, 32'd6, 64'd30));
    step();
    set_in(mk(1'b0, 32'd7, 32'd8, 64'd56));
    step();
    cancel = 1'b1;
    set_in(mk(1'b0, 32'd9, 32'd9, 64'd81));
    step();
    cancel = 1'b0;
    in_valid = 1'b0;
    chk("cancel busy", 64'(busy), 64'h0);
    chk("cancel out", 64'(out_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("cancel none%0d", k), 64'(out_valid), 64'h0);
    end
    chk("cancel res hold", res, 64'd12);

    set_in(mk(1'b0, 32'd2, 32'd3, 64'd6));
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre-cancel valid", 64'(out_valid), 64'h1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel output valid", 64'(out_valid), 64'h0);
    chk("cancel output res", res, 64'd6);

    set_in(mk(1'b0, 32'd4, 32'd5, 64'd20));
    step();
    in_valid = 1'b0;
    stall = 1'b1;
    cancel = 1'b1;
    step();
    stall = 1'b0;
    cancel = 1'b0;
    chk("cancel beats stall", 64'(busy), 64'h0);

    set_in(mk(1'b0, 32'd4, 32'd4, 64'd16));
    step();
    in_valid = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midreset out", 64'(out_valid), 64'h0);
    chk("midreset res", res, 64'h0);
    chk("midreset busy", 64'(busy), 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("midreset none%0d", k), 64'(out_valid), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
Parametrised, fully pipelined integer multiplier for the EX/MEM path of the CPU core. It serves MULT/MULTU, and MADD/MSUB when compiled with accumulate.
- Generalises the single-op multiplier wrapper in four ways: configurable width and latency, per-op signed/unsigned mode, one new op accepted every cycle, and pipeline-freeze (stall) support.
- The implementation is pure RTL; no vendor IP.

Parameters:
WIDTH, 32, operand width in bits (>=2)
DEPTH, 3, issue-to-result latency in cycles (>=1)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
in_valid  in  1  issue an op this cycle
is_signed  in  1  1 = signed operands, 0 = unsigned; sampled with in_valid
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
stall  in  1  freeze all stages, the output register and the outputs
cancel  in  1  flush every in-flight op (exception/branch flush)
res  out  2*WIDTH  product; {HI,LO} when WIDTH=32
out_valid  out  1  res is the result of a completed op
busy  out  1  at least one op in flight in stages 1..DEPTH-1

Behaviour:
- Reset (resetn=0 at posedge): all stage valid bits=0, out_valid=0, res=0. Reset mid-operation discards all in-flight ops; no out_valid pulse follows.
- Extension: when is_signed=1, a and b are sign-extended to WIDTH+1 bits; otherwise they are zero-extended. The (2*WIDTH+2)-bit signed product is truncated to its low 2*WIDTH bits.
- Pipeline: DEPTH register stages, each holding a valid bit plus data.
  - Stage 1 captures the extended operands and mode.
  - The product is formed between stage 1 and stage 2, then carried through the remaining stages; the layout is retiming-friendly.
  - The stage-DEPTH register drives res and out_valid. When DEPTH=1, the product is registered directly at stage 1.
- Latency: an op issued at edge N (in_valid=1, stall=0, cancel=0) sets out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles after issue, provided there is no stall.
- Throughput: one op per cycle; back-to-back issues give back-to-back out_valid.
- out_valid is high for exactly one cycle per op unless stalled. When out_valid is low, res holds the last completed result; it is never cleared except by reset.
- stall=1: no register changes, in_valid is ignored and the op is dropped, and out_valid/res hold their current value.
- cancel=1: all stage valid bits and out_valid clear at the next edge; in_valid that same cycle is dropped; res data holds.
- Priority: resetn > cancel > stall > in_valid.
- busy = OR of the valid bits of stages 1..DEPTH-1, so busy is combinational from state. With DEPTH=1, busy=0.

Optional Feature:
MUL_ACC_EN
- Defined: adds these ports:
  - acc_op in 2: 00 = plain, 01 = add (MADD), 10 = sub (MSUB), 11 = reserved, treated as plain.
  - acc_in in 2*WIDTH: current HI/LO.
  Both are captured at issue. The final stage computes acc_in +/- product, modulo 2^(2*WIDTH). Latency is unchanged.
- Undefined: ports absent; the block behaves as a plain multiplier.

Decomposition:
- Package mul_pkg: acc_op encodings (ACC_NONE/ACC_ADD/ACC_SUB) and the acc_op width constant.
- One sub-module, mul_pipe_reg: a parametrised valid+data register stage with stall/cancel/reset. It is instantiated DEPTH times via generate.

Test Plan:
- WIDTH=32, DEPTH=3, signed, a=0xFFFFFFFF (-1), b=2 -> out_valid 3 cycles after issue, res=0xFFFFFFFF_FFFFFFFE.
- Unsigned, a=b=0xFFFFFFFF -> res=0xFFFFFFFE_00000001. Signed, a=0x80000000, b=0x80000000 -> res=0x40000000_00000000.
- Three consecutive issues (3*4, 5*6, 7*8 unsigned) -> out_valid high 3 consecutive cycles, res=12, 30, 56.
- Issue op, assert stall for 2 cycles at cycle 1 -> out_valid after 5 cycles, res correct; out_valid stays high while stalled at output.
- Issue 2 ops, cancel at cycle 2 together with a new in_valid -> no out_valid ever, busy=0 next cycle, res unchanged. Reset at cycle 1 -> out_valid=0, res=0.
- MUL_ACC_EN: acc_in=0x00000000_00000010, acc_op=SUB, signed 3*5 -> res=0x00000000_00000001. acc_op=ADD with acc_in=0xFFFFFFFF_FFFFFFFF, 1*1 -> res=0 (wrap).
